imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into RISC-V instruction bits [31:7]
// for the I/B/J/S/U formats (the inverse of the immediate decoder).
//
// Two-stage valid/ready pipeline:
//   S1 holds the accepted request (imm, op).
//   S2 holds the packed result and the error flag.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   request accepted when in_valid && in_ready
//   in_imm     immediate to pack
//   in_op      format: 0=I 1=B 2=J 3=S 4=U, 5..7 illegal
//   out_valid  result present
//   out_ready  result consumed when out_valid && out_ready
//   out_din    packed bits [31:7]; out_din[k] is instruction bit k+7
//   out_err    immediate not representable, or illegal op (out_din is 0)
//   err_clr    synchronous clear of err_cnt (wins over an increment)
//   err_cnt    saturating count of consumed results with out_err=1
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_imm,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [24:0]          out_din,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] OpI = 3'd0;
  localparam logic [2:0] OpB = 3'd1;
  localparam logic [2:0] OpJ = 3'd2;
  localparam logic [2:0] OpS = 3'd3;
  localparam logic [2:0] OpU = 3'd4;

  logic                 s1_valid_q;
  logic [31:0]          s1_imm_q;
  logic [2:0]           s1_op_q;
  logic                 s2_valid_q;
  logic [24:0]          s2_din_q;
  logic                 s2_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic        s2_load;
  logic        s1_advance;
  logic [24:0] pack_din;
  logic        pack_ok;

  // S2 frees up when empty or being consumed; S1 moves along with it.
  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_advance = s2_load;
  assign in_ready   = !s1_valid_q || s1_advance;

  // Pack the S1 request; range checks require the bits above the field's
  // sign bit to be a pure sign extension.
  always_comb begin
    pack_din = '0;
    pack_ok  = 1'b0;
    case (s1_op_q)
      OpI: begin
        pack_din[24:13] = s1_imm_q[11:0];
        pack_ok         = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
      end
      OpB: begin
        pack_din[24]    = s1_imm_q[12];
        pack_din[0]     = s1_imm_q[11];
        pack_din[23:18] = s1_imm_q[10:5];
        pack_din[4:1]   = s1_imm_q[4:1];
        pack_ok         = ((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) && !s1_imm_q[0];
      end
      OpJ: begin
        pack_din[24]    = s1_imm_q[20];
        pack_din[12:5]  = s1_imm_q[19:12];
        pack_din[13]    = s1_imm_q[11];
        pack_din[23:14] = s1_imm_q[10:1];
        pack_ok         = ((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) && !s1_imm_q[0];
      end
      OpS: begin
        pack_din[24:18] = s1_imm_q[11:5];
        pack_din[4:0]   = s1_imm_q[4:0];
        pack_ok         = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
      end
      OpU: begin
        pack_din[24:5] = s1_imm_q[31:12];
        pack_ok        = !(|s1_imm_q[11:0]);
      end
      default: begin
        pack_din = '0;
        pack_ok  = 1'b0;
      end
    endcase
    if (!pack_ok) begin
      pack_din = '0;
    end
  end

  // Stage 1: request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_op_q    <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_imm_q <= in_imm;
        s1_op_q  <= in_op;
      end
    end
  end

  // Stage 2: packed result. Data only changes when a new result arrives,
  // so it holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_din_q   <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_din_q <= pack_din;
        s2_err_q <= !pack_ok;
      end
    end
  end

  // Error counter: clear beats increment; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_q;
  assign out_din   = s2_din_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
